// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access size encoding,
// FSM state encoding, default data-RAM window and the access legality check.
package lsu_pkg;

    localparam int unsigned MEM_BYTES_DEFAULT = 4096;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_BAD  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_READ  = 3'd1,
        LD_WAIT  = 3'd2,
        ST_READ  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_WRITE = 3'd5,
        DONE     = 3'd6
    } state_e;

    function automatic logic [2:0] size_bytes(input size_e size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

    // True when the access is misaligned, of illegal size, or runs past the window.
    function automatic logic access_error(input size_e size, input logic [31:0] addr,
                                          input logic [32:0] window);
        logic        misaligned;
        logic [32:0] end_addr;
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr[0];
            SIZE_WORD: misaligned = |addr[1:0];
            default:   misaligned = 1'b1;
        endcase
        end_addr = {1'b0, addr} + {30'd0, size_bytes(size)};
        return misaligned || (end_addr > window);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a RAM word,
// and merges store data into the addressed lane(s) of a RAM word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] shifted_s;
    logic [15:0] half_s;

    // Lane extraction with sign/zero extension, and lane replacement for stores.
    always_comb begin
        shifted_s  = rdata >> {offset, 3'b000};
        half_s     = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data  = 32'h0000_0000;
        merge_data = rdata;
        case (size)
            SIZE_BYTE: begin
                load_data = is_unsigned ? {24'h00_0000, shifted_s[7:0]}
                                        : {{24{shifted_s[7]}}, shifted_s[7:0]};
                merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
                merge_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SIZE_WORD: begin
                load_data  = rdata;
                merge_data = wdata;
            end
            default: begin
                load_data  = 32'h0000_0000;
                merge_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a synchronous-read data RAM;
// sub-word stores are done as read-modify-write of the containing word.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_e      state_r;
    state_e      next_state_s;
    logic        write_r;
    size_e       size_r;
    logic        unsigned_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;

    logic        accept_s;
    logic        req_err_s;
    size_e       req_size_s;
    logic [31:0] addr_next_s;
    logic [31:0] load_data_s;
    logic [31:0] merge_data_s;

    assign req_size_s  = size_e'(req_size);
    assign accept_s    = req_valid && (state_r == IDLE);
    assign req_err_s   = access_error(req_size_s, req_addr, 33'(MEM_BYTES));
    assign addr_next_s = accept_s ? req_addr : addr_r;

    lsu_lane_align u_lane_align (
        .size        (size_r),
        .offset      (addr_r[1:0]),
        .is_unsigned (unsigned_r),
        .rdata       (mem_read_data),
        .wdata       (wdata_r),
        .load_data   (load_data_s),
        .merge_data  (merge_data_s)
    );

    // Next-state logic for the access sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    next_state_s = IDLE;
                end else if (req_err_s) begin
                    next_state_s = DONE;
                end else if (!req_write) begin
                    next_state_s = LD_READ;
                end else if (req_size_s == SIZE_WORD) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_READ;
                end
            end
            LD_READ:  next_state_s = LD_WAIT;
            LD_WAIT:  next_state_s = DONE;
            ST_READ:  next_state_s = ST_WAIT;
            ST_WAIT:  next_state_s = ST_WRITE;
            ST_WRITE: next_state_s = DONE;
            DONE:     next_state_s = IDLE;
            default:  next_state_s = IDLE;
        endcase
    end

    // State register and request capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            write_r    <= 1'b0;
            size_r     <= SIZE_BYTE;
            unsigned_r <= 1'b0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                write_r    <= req_write;
                size_r     <= req_size_s;
                unsigned_r <= req_unsigned;
                addr_r     <= req_addr;
                wdata_r    <= req_wdata;
            end
        end
    end

    // Handshake and RAM strobes are registered from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= 32'h0000_0000;
        end else begin
            req_ready   <= (next_state_s == IDLE);
            resp_valid  <= (next_state_s == DONE);
            mem_write   <= (next_state_s == ST_WRITE);
            mem_address <= (next_state_s != IDLE) ? {addr_next_s[31:2], 2'b00} : 32'h0000_0000;
        end
    end

    // Response data/error and the RAM write word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_rdata     <= 32'h0000_0000;
            resp_err       <= 1'b0;
            mem_write_data <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                resp_rdata <= 32'h0000_0000;
                resp_err   <= req_err_s;
                if (req_write && (req_size_s == SIZE_WORD) && !req_err_s) begin
                    mem_write_data <= req_wdata;
                end
            end else if (state_r == LD_WAIT) begin
                resp_rdata <= load_data_s;
            end else if ((state_r == ST_WAIT) && write_r) begin
                mem_write_data <= merge_data_s;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed scenarios plus randomized accesses checked
// against a byte-array reference memory and the documented per-kind latencies.
module tb_load_store_unit;

    localparam int MEMB = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] ram_words [0:MEMB/4-1];
    logic [7:0]  ref_bytes [0:MEMB-1];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEMB)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Synchronous-read data RAM seen by the DUT.
    always @(posedge clk) begin
        if (mem_write && (mem_address < 32'(MEMB))) ram_words[mem_address[11:2]] <= mem_write_data;
        mem_read_data <= ram_words[mem_address[11:2]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload_word(input int waddr, input logic [31:0] val);
        ram_words[waddr] = val;
        for (int b = 0; b < 4; b++) ref_bytes[waddr*4+b] = val[b*8 +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int base);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[b*8 +: 8] = ref_bytes[base+b];
        return w;
    endfunction

    // One access: model the expected outcome, drive it, observe up to 10 cycles.
    task automatic run_access(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd, input string tag,
                              output logic [31:0] got_rdata, output logic got_err);
        int          nbytes, lat, resp_cyc, wr_cyc, wr_cnt;
        logic        exp_err;
        logic [31:0] exp_rdata, exp_wword, wr_data, wr_addr, mask;
        longint      last;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        last = longint'(addr) + longint'(nbytes);
        exp_err = (sz == 2'd3) || (nbytes == 2 && addr[0]) || (nbytes == 4 && addr[1:0] != 2'd0)
                  || (last > longint'(MEMB));
        exp_rdata = 32'h0;
        exp_wword = 32'h0;
        if (!exp_err && !wr) begin
            for (int b = 0; b < nbytes; b++) exp_rdata[b*8 +: 8] = ref_bytes[int'(addr)+b];
            if (!uns && nbytes < 4 && exp_rdata[nbytes*8-1]) begin
                mask = (32'h1 << (nbytes*8)) - 32'h1;
                exp_rdata = exp_rdata | ~mask;
            end
        end else if (!exp_err) begin
            for (int b = 0; b < nbytes; b++) ref_bytes[int'(addr)+b] = wd[b*8 +: 8];
            exp_wword = ref_word(int'({addr[31:2], 2'b00}));
        end
        lat = exp_err ? 1 : !wr ? 3 : (nbytes == 4) ? 2 : 4;

        @(negedge clk);
        check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        resp_cyc = -1; wr_cyc = -1; wr_cnt = 0;
        wr_data = 32'h0; wr_addr = 32'h0; got_rdata = 32'h0; got_err = 1'b0;
        for (int k = 1; k <= 10 && resp_cyc < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
                req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
                check_eq({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
            end
            if (mem_write) begin
                wr_cnt++; wr_cyc = k; wr_data = mem_write_data; wr_addr = mem_address;
            end
            if (resp_valid) begin
                resp_cyc = k; got_rdata = resp_rdata; got_err = resp_err;
            end
        end
        check_eq({tag, "_lat"}, 32'(resp_cyc), 32'(lat));
        check_eq({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
        check_eq({tag, "_rdata"}, got_rdata, exp_rdata);
        check_eq({tag, "_nwr"}, 32'(wr_cnt), (wr && !exp_err) ? 32'd1 : 32'd0);
        if (wr && !exp_err) begin
            check_eq({tag, "_wrcyc"}, 32'(wr_cyc), 32'(lat - 1));
            check_eq({tag, "_wrdata"}, wr_data, exp_wword);
            check_eq({tag, "_wraddr"}, wr_addr, {addr[31:2], 2'b00});
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          seen;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int w = 0; w < MEMB/4; w++) preload_word(w, $urandom);
        preload_word(2, 32'h8899AABB);
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_outs", {29'd0, resp_valid, resp_err, mem_write}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_maddr", mem_address, 32'd0);
        check_eq("rst_mwdata", mem_write_data, 32'd0);
        reset = 1'b0;

        run_access(1'b0, 2'd0, 1'b0, 32'h9, 32'h0, "lb_sx", rd, er);
        check_eq("lb_sx_val", rd, 32'hFFFFFFAA);
        run_access(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, "lhu", rd, er);
        check_eq("lhu_val", rd, 32'h00008899);
        run_access(1'b1, 2'd1, 1'b0, 32'h8, 32'h00001234, "sh", rd, er);
        check_eq("sh_ram", ram_words[2], 32'h88991234);
        run_access(1'b1, 2'd2, 1'b0, 32'h6, 32'h11111111, "sw_mis", rd, er);
        check_eq("sw_mis_e", {31'd0, er}, 32'd1);
        run_access(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, "lw_oob", rd, er);
        check_eq("lw_oob_e", {31'd0, er}, 32'd1);
        run_access(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, "sz_bad", rd, er);
        run_access(1'b0, 2'd0, 1'b1, 32'hFFF, 32'h0, "lb_top", rd, er);
        run_access(1'b0, 2'd1, 1'b0, 32'hFFF, 32'h0, "lh_odd", rd, er);

        // Reset while a byte store sits in its read-modify-write wait state.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h5A;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1; #1;
        check_eq("rstw_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rstw_outs", {30'd0, resp_valid, mem_write}, 32'd0);
        check_eq("rstw_maddr", mem_address, 32'd0);
        @(negedge clk); reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_write || resp_valid) seen++;
        end
        check_eq("rstw_quiet", 32'(seen), 32'd0);
        check_eq("rstw_ram", ram_words[8], ref_word(32));

        run_access(1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, "sw0", rd, er);
        run_access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "lw0", rd, er);
        check_eq("lw0_val", rd, 32'hCAFEF00D);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            logic [1:0]  s;
            a = (t % 8 == 7) ? (32'(MEMB) - 32'($urandom_range(1, 4))) : 32'($urandom_range(0, MEMB-1));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 1)) << 1;
            s = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_access(1'($urandom), s, 1'($urandom), a, $urandom, $sformatf("rnd%0d", t), rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
